// File: rtl/slave_arbiter.sv
// Round-robin arbiter that shares one slave target between NUM_MASTERS requesters.
// Optional ack-wait timeout is built when SLAVE_ARB_TIMEOUT_EN is defined.
module slave_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_cmd,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [31:0]               m_rdata,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      slave_req,
  output logic                      slave_cmd,
  output logic [31:0]               slave_wdata,
  input  logic                      slave_ack,
  input  logic [31:0]               slave_rdata
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StAckHi, StAckLo, StDone, StGap} state_e;

  state_e                 state;
  logic [1:0]             ptr;
  logic [GapW-1:0]        gap_cnt;
  logic                   found;
  logic [1:0]             pick;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic                   timeout;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= int'(NUM_MASTERS)) s = s - int'(NUM_MASTERS);
    return 2'(s);
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
      if (m_req[rr_idx(ptr, k)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr, k);
      end
    end
  end

  always_comb begin
    grant_oh           = '0;
    grant_oh[grant_id] = 1'b1;
  end

`ifdef SLAVE_ARB_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [ToW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != StAckHi) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == StAckHi) && !slave_ack && (to_cnt == ToW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      ptr         <= '0;
      gap_cnt     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      slave_req   <= 1'b0;
      slave_cmd   <= 1'b0;
      slave_wdata <= '0;
      m_ack       <= '0;
      m_err       <= '0;
      m_rdata     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (found) begin
            grant_id    <= pick;
            slave_cmd   <= m_cmd[pick];
            slave_wdata <= m_wdata[{pick, 5'd0} +: 32];
            busy        <= 1'b1;
            state       <= StReq;
          end
        end
        StReq: begin
          slave_req <= 1'b1;
          state     <= StAckHi;
        end
        StAckHi: begin
          if (slave_ack) begin
            state <= StAckLo;
          end else if (timeout) begin
            slave_req <= 1'b0;
            m_ack     <= grant_oh;
            m_err     <= grant_oh;
            m_rdata   <= '0;
            state     <= StDone;
          end
        end
        StAckLo: begin
          if (!slave_ack) begin
            slave_req <= 1'b0;
            m_ack     <= grant_oh;
            m_rdata   <= slave_cmd ? 32'd0 : slave_rdata;
            state     <= StDone;
          end
        end
        StDone: begin
          m_ack   <= '0;
          m_err   <= '0;
          m_rdata <= '0;
          ptr     <= (grant_id == 2'(NUM_MASTERS - 1)) ? 2'd0 : grant_id + 2'd1;
          gap_cnt <= '0;
          state   <= StGap;
        end
        StGap: begin
          if (gap_cnt == GapW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Self-checking bench for slave_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based round-robin model.
module tb_slave_arbiter;

  localparam int unsigned NM  = 3;
  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_cmd, m_ack, m_err;
  logic [32*NM-1:0]  m_wdata;
  logic [31:0]       m_rdata, slave_wdata, slave_rdata;
  logic [1:0]        grant_id;
  logic              busy, slave_req, slave_cmd, slave_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  slave_arbiter #(
    .NUM_MASTERS   (NM),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req      (m_req),
    .m_cmd      (m_cmd),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .m_rdata    (m_rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .slave_req  (slave_req),
    .slave_cmd  (slave_cmd),
    .slave_wdata(slave_wdata),
    .slave_ack  (slave_ack),
    .slave_rdata(slave_rdata)
  );

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk);
  endtask

  // Acts as the slave for one transaction and returns what the DUT showed.
  task automatic do_txn(input int dly, input int len, input logic [31:0] rd,
                        output int waited, output logic [1:0] g, output logic c,
                        output logic [31:0] wd, output bit stable,
                        output logic [NM-1:0] ack, output logic [NM-1:0] err,
                        output logic [31:0] rdo, output logic sreq);
    waited = 0; stable = 1'b1; g = '0; c = 1'b0; wd = '0;
    ack = '0; err = '0; rdo = '0; sreq = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (slave_req !== 1'b1 && waited < 100);
    if (slave_req !== 1'b1) begin
      waited = -1;
      return;
    end
    g = grant_id; c = slave_cmd; wd = slave_wdata;
    repeat (dly) begin
      @(negedge clk);
      if (slave_req !== 1'b1 || slave_cmd !== c || slave_wdata !== wd) stable = 1'b0;
    end
    slave_ack = 1'b1;
    slave_rdata = rd;
    repeat (len) begin
      @(negedge clk);
      if (slave_req !== 1'b1 || slave_cmd !== c || slave_wdata !== wd) stable = 1'b0;
    end
    slave_ack = 1'b0;
    @(negedge clk);
    ack = m_ack; err = m_err; rdo = m_rdata; sreq = slave_req;
    slave_rdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = '0; m_cmd = '0; m_wdata = '0; slave_ack = 1'b0; slave_rdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, slave_req, slave_cmd, grant_id, m_ack, m_err} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, slave_req, slave_cmd, grant_id, m_ack, m_err});
    end
    total++;
    if ({slave_wdata, m_rdata} !== 64'd0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {slave_wdata, m_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int w; logic [1:0] g; logic c; logic [31:0] wd, rdo; bit st;
    logic [NM-1:0] ack, err; logic sr;
    wait_idle();
    m_req = 3'b001; m_cmd = 3'b000;
    do_txn(2, 1, 32'hA5A5_0001, w, g, c, wd, st, ack, err, rdo, sr);
    m_req = '0;
    total++;
    if (w !== 2) begin bad++; $display("FAIL read_latency: got %0d want 2", w); end
    total++;
    if ({g, ack, err, sr} !== {2'd0, 3'b001, 3'b000, 1'b0}) begin
      bad++;
      $display("FAIL read_ack: got g=%0d ack=%b err=%b sreq=%b want g=0 ack=001 err=000 sreq=0",
               g, ack, err, sr);
    end
    total++;
    if (rdo !== 32'hA5A5_0001) begin
      bad++; $display("FAIL read_data: got %h want a5a50001", rdo);
    end
    @(negedge clk);
    total++;
    if ({m_ack, m_err, m_rdata, busy} !== {3'b0, 3'b0, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL read_clear: got ack=%b err=%b rdata=%h busy=%b want 0/0/0/1",
               m_ack, m_err, m_rdata, busy);
    end
  endtask

  task automatic test_write_drop();
    int w; logic [1:0] g; logic c; logic [31:0] wd, rdo; bit st;
    logic [NM-1:0] ack, err; logic sr;
    wait_idle();
    m_req = 3'b010; m_cmd = 3'b010; m_wdata[63:32] = 32'h1234_5678;
    @(negedge clk);
    m_req = '0;  // granted master withdraws; transaction must still complete
    do_txn(2, 2, 32'hDEAD_BEEF, w, g, c, wd, st, ack, err, rdo, sr);
    total++;
    if ({w, g, c, wd} !== {32'd1, 2'd1, 1'b1, 32'h1234_5678}) begin
      bad++;
      $display("FAIL write_cmd: got w=%0d g=%0d cmd=%b wdata=%h want 1/1/1/12345678", w, g, c, wd);
    end
    total++;
    if (st !== 1'b1) begin bad++; $display("FAIL write_stable: got %b want 1", st); end
    total++;
    if ({ack, rdo, sr} !== {3'b010, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL write_ack: got ack=%b rdata=%h sreq=%b want 010/0/0", ack, rdo, sr);
    end
  endtask

  task automatic test_contention();
    int w; logic [1:0] g; logic c; logic [31:0] wd, rdo, rd; bit st;
    logic [NM-1:0] ack, err, oh; logic sr;
    wait_idle();
    m_req = 3'b011; m_cmd = 3'(($urandom & 3));
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      do_txn($urandom_range(0, 3), $urandom_range(1, 3), rd, w, g, c, wd, st, ack, err, rdo, sr);
      oh = '0; oh[i % 2] = 1'b1;
      total++;
      if ({g, ack} !== {2'(i % 2), oh}) begin
        bad++;
        $display("FAIL cont_grant%0d: got g=%0d ack=%b want g=%0d ack=%b", i, g, ack, i % 2, oh);
      end
      total++;
      if (rdo !== (c ? 32'd0 : rd)) begin
        bad++; $display("FAIL cont_rdata%0d: got %h want %h", i, rdo, c ? 32'd0 : rd);
      end
      if (i > 0) begin
        total++;
        if (w < int'(GAP) + 2) begin
          bad++; $display("FAIL cont_gap%0d: got %0d want >= %0d", i, w, GAP + 2);
        end
      end
    end
    m_req = '0;
  endtask

  task automatic test_ptr_wrap();
    int w; logic [1:0] g; logic c; logic [31:0] wd, rdo; bit st;
    logic [NM-1:0] ack, err; logic sr;
    wait_idle();
    m_req = 3'b100;
    do_txn(1, 1, 32'h0, w, g, c, wd, st, ack, err, rdo, sr);
    m_req = '0;
    total++;
    if ({g, ack} !== {2'd2, 3'b100}) begin
      bad++; $display("FAIL wrap_m2: got g=%0d ack=%b want 2/100", g, ack);
    end
    wait_idle();
    m_req = 3'b101;
    do_txn(1, 1, 32'h0, w, g, c, wd, st, ack, err, rdo, sr);
    m_req = '0;
    total++;
    if ({g, ack} !== {2'd0, 3'b001}) begin
      bad++; $display("FAIL wrap_m0: got g=%0d ack=%b want 0/001", g, ack);
    end
  endtask

  task automatic test_reset_mid();
    int w; logic [1:0] g; logic c; logic [31:0] wd, rdo; bit st;
    logic [NM-1:0] ack, err; logic sr; int k;
    wait_idle();
    m_req = 3'b010;  // leaves the pointer at 2
    do_txn(0, 1, 32'h0, w, g, c, wd, st, ack, err, rdo, sr);
    m_req = '0;
    wait_idle();
    m_req = 3'b100;
    k = 0;
    while (slave_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    total++;
    if (slave_req !== 1'b1) begin bad++; $display("FAIL rstmid_start: got 0 want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({slave_req, busy, m_ack} !== '0) begin
      bad++; $display("FAIL rstmid_clear: got %b want 0", {slave_req, busy, m_ack});
    end
    rst = 1'b0;
    m_req = 3'b101;
    do_txn(1, 1, 32'h0, w, g, c, wd, st, ack, err, rdo, sr);
    m_req = '0;
    total++;
    if ({g, ack} !== {2'd0, 3'b001}) begin
      bad++; $display("FAIL rstmid_ptr: got g=%0d ack=%b want 0/001", g, ack);
    end
  endtask

`ifdef SLAVE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    wait_idle();
    m_req = 3'b001; m_cmd = 3'b000; slave_ack = 1'b0; slave_rdata = 32'hFFFF_FFFF;
    k = 0;
    while (slave_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (m_ack === '0 && k < 40) begin @(negedge clk); k++; end
    m_req = '0;
    total++;
    if (k !== int'(TO)) begin bad++; $display("FAIL to_latency: got %0d want %0d", k, TO); end
    total++;
    if ({m_ack, m_err, m_rdata} !== {3'b001, 3'b001, 32'd0}) begin
      bad++; $display("FAIL to_pulse: got ack=%b err=%b rdata=%h want 001/001/0", m_ack, m_err, m_rdata);
    end
  endtask
`endif

  task automatic test_random();
    logic [32:0] q[NM][$];
    int ptr, exp_w, w, n;
    logic [1:0] g; logic c; logic [31:0] wd, rdo, rd; bit st;
    logic [NM-1:0] ack, err, oh; logic sr; logic [32:0] head;
    wait_idle();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < int'(NM); i++) begin
      n = (i == 0) ? $urandom_range(1, 5) : $urandom_range(0, 5);
      for (int j = 0; j < n; j++) q[i].push_back({1'($urandom), 32'($urandom)});
    end
    for (int it = 0; it < 40; it++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      for (int i = 0; i < int'(NM); i++) begin
        m_req[i] = (q[i].size() > 0);
        if (q[i].size() > 0) begin
          m_cmd[i] = q[i][0][32];
          m_wdata[32*i +: 32] = q[i][0][31:0];
        end
      end
      exp_w = -1;
      for (int k = 0; k < int'(NM); k++)
        if (exp_w < 0 && q[(ptr + k) % NM].size() > 0) exp_w = (ptr + k) % NM;
      head = q[exp_w][0];
      rd = $urandom;
      do_txn($urandom_range(0, 4), $urandom_range(1, 3), rd, w, g, c, wd, st, ack, err, rdo, sr);
      oh = '0; oh[exp_w] = 1'b1;
      total++;
      if (w < 0 || {g, c, wd, st} !== {2'(exp_w), head, 1'b1}) begin
        bad++;
        $display("FAIL rnd_grant%0d: got w=%0d g=%0d cmd=%b wdata=%h stable=%b want g=%0d cmd=%b wdata=%h",
                 it, w, g, c, wd, st, exp_w, head[32], head[31:0]);
      end
      total++;
      if ({ack, err, sr, rdo} !== {oh, 3'b000, 1'b0, head[32] ? 32'd0 : rd}) begin
        bad++;
        $display("FAIL rnd_done%0d: got ack=%b err=%b sreq=%b rdata=%h want ack=%b err=0 sreq=0 rdata=%h",
                 it, ack, err, sr, rdo, oh, head[32] ? 32'd0 : rd);
      end
      void'(q[exp_w].pop_front());
      ptr = (exp_w + 1) % NM;
    end
    m_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_drop();
    test_contention();
    test_ptr_wrap();
    test_reset_mid();
`ifdef SLAVE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
